// File: rtl/freq_div_mon.sv
// Odd-ratio divider health monitor: counts div3/div5/div7 rising edges per WIN-cycle window and flags pass/lock.
// Optional sticky per-channel error flags with FREQ_DIV_MON_STICKY_ERR_EN.
module freq_div_mon #(
    parameter int unsigned WIN    = 210,
    parameter int unsigned TOL    = 1,
    parameter int unsigned CW     = 8,
    parameter int unsigned SETTLE = 4,
    parameter int unsigned LOCK_N = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          div3,
    input  logic          div5,
    input  logic          div7,
    output logic [CW-1:0] cnt3,
    output logic [CW-1:0] cnt5,
    output logic [CW-1:0] cnt7,
    output logic [2:0]    ok,
    output logic          done,
    output logic          lock
`ifdef FREQ_DIV_MON_STICKY_ERR_EN
    ,input  logic         err_clr
    ,output logic [2:0]   err
`endif
);

    localparam int unsigned WW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int unsigned SW = $clog2(SETTLE + 1);
    localparam int unsigned RW = $clog2(LOCK_N + 1);
    localparam int unsigned EW = CW + 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_MEASURE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2:0]           r_s1, r_s2, r_s3;
    logic [2:0]           w_edge;
    logic [SW-1:0]        r_settle;
    logic [WW-1:0]        r_win;
    logic [2:0][CW-1:0]   r_ec;
    logic [2:0][CW-1:0]   w_ec_nxt;
    logic [2:0]           w_ok_nxt;
    logic                 w_terminal;
    logic                 w_all_pass;
    logic [RW-1:0]        r_run;
    logic [RW-1:0]        w_run_nxt;
    logic                 w_lock_nxt;

    // Absolute deviation from the ideal count, evaluated with headroom so it cannot wrap.
    function automatic logic within_tol(input logic [CW-1:0] c, input int unsigned p);
        logic signed [EW-1:0] d;
        d = $signed({2'b00, c}) - $signed(EW'(WIN / p));
        if (d < 0) d = -d;
        return (d <= $signed(EW'(TOL)));
    endfunction

    assign w_edge = r_s2 & ~r_s3;

    always_comb begin
        w_state_nxt = r_state;
        w_terminal  = 1'b0;
        w_ec_nxt    = r_ec;
        w_ok_nxt    = 3'b000;
        w_all_pass  = 1'b0;
        w_run_nxt   = '0;
        w_lock_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (en) w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (!en)                  w_state_nxt = S_IDLE;
                else if (r_settle == '0)  w_state_nxt = S_MEASURE;
            end
            S_MEASURE: begin
                if (!en) w_state_nxt = S_IDLE;
                else     w_terminal  = (r_win == WW'(WIN - 1));
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Saturating edge counts including this cycle's edge, and the verdict they would produce.
        for (int unsigned i = 0; i < 3; i++) begin
            if (w_edge[i] && (r_ec[i] != {CW{1'b1}})) w_ec_nxt[i] = r_ec[i] + CW'(1);
            w_ok_nxt[i] = within_tol(w_ec_nxt[i], 3 + 2 * i);
        end

        w_all_pass = (w_ok_nxt == 3'b111);
        if (w_all_pass) w_run_nxt = (r_run < RW'(LOCK_N)) ? r_run + RW'(1) : r_run;
        w_lock_nxt = w_all_pass && (w_run_nxt >= RW'(LOCK_N));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_s1     <= '0;
            r_s2     <= '0;
            r_s3     <= '0;
            r_settle <= '0;
            r_win    <= '0;
            r_ec     <= '0;
            r_run    <= '0;
            cnt3     <= '0;
            cnt5     <= '0;
            cnt7     <= '0;
            ok       <= 3'b000;
            done     <= 1'b0;
            lock     <= 1'b0;
        end else begin
            r_s1    <= {div7, div5, div3};
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_state <= w_state_nxt;
            done    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_settle <= SW'(SETTLE - 1);
                end
                S_SETTLE: begin
                    if (r_settle != '0) r_settle <= r_settle - SW'(1);
                    r_win <= '0;
                    r_ec  <= '0;
                end
                S_MEASURE: begin
                    if (w_terminal) begin
                        // Publish and restart with no gap so back-to-back windows lose no edge.
                        cnt3  <= w_ec_nxt[0];
                        cnt5  <= w_ec_nxt[1];
                        cnt7  <= w_ec_nxt[2];
                        ok    <= w_ok_nxt;
                        done  <= 1'b1;
                        r_run <= w_run_nxt;
                        lock  <= w_lock_nxt;
                        r_win <= '0;
                        r_ec  <= '0;
                    end else begin
                        r_win <= r_win + WW'(1);
                        r_ec  <= w_ec_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FREQ_DIV_MON_STICKY_ERR_EN
    // A failing verdict sets its flag even when a clear arrives in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 3'b000;
        end else if (r_state == S_MEASURE && w_terminal) begin
            err <= (err_clr ? 3'b000 : err) | ~w_ok_nxt;
        end else if (err_clr) begin
            err <= 3'b000;
        end
    end
`endif

endmodule

// File: tb/tb_freq_div_mon.sv
// Randomized self-checking bench for freq_div_mon against a window-level arithmetic model.
// Sticky-error scenarios are built when FREQ_DIV_MON_STICKY_ERR_EN is defined.
module tb_freq_div_mon;

    localparam int WIN    = 210;
    localparam int TOL    = 1;
    localparam int CW     = 8;
    localparam int CW6    = 6;
    localparam int LOCK_N = 2;

    logic clk = 1'b0;
    logic rst, en, div3, div5, div7;
    logic [CW-1:0]  cnt3, cnt5, cnt7;
    logic [2:0]     ok;
    logic           done, lock;
    logic [CW6-1:0] s_cnt3, s_cnt5, s_cnt7;
    logic [2:0]     s_ok;
    logic           s_done, s_lock;
`ifdef FREQ_DIV_MON_STICKY_ERR_EN
    logic       err_clr;
    logic [2:0] err, s_err;
`endif

    int         per[3];
    int         stuck[3];
    int         h[3];
    logic [2:0] g;
    logic       force5;
    int         n_run, n_fail, m_run;

    always #5 clk = ~clk;

    // Square waves of per[i] clk cycles, toggling on both clock edges like the real divider.
    always @(posedge clk or negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (per[i] == 0) begin
                g[i] <= stuck[i][0];
                h[i] <= 0;
            end else begin
                h[i] <= (h[i] + 1) % (2 * per[i]);
                g[i] <= (h[i] < per[i]);
            end
        end
    end

    assign div3 = g[0];
    assign div5 = force5 ? 1'b0 : g[1];
    assign div7 = g[2];

    freq_div_mon #(.WIN(WIN), .TOL(TOL), .CW(CW), .SETTLE(4), .LOCK_N(LOCK_N)) u_dut (
        .clk (clk), .rst (rst), .en (en),
        .div3(div3), .div5(div5), .div7(div7),
        .cnt3(cnt3), .cnt5(cnt5), .cnt7(cnt7),
        .ok  (ok), .done(done), .lock(lock)
`ifdef FREQ_DIV_MON_STICKY_ERR_EN
        ,.err_clr(err_clr)
        ,.err    (err)
`endif
    );

    freq_div_mon #(.WIN(WIN), .TOL(TOL), .CW(CW6), .SETTLE(4), .LOCK_N(LOCK_N)) u_dut6 (
        .clk (clk), .rst (rst), .en (en),
        .div3(div3), .div5(div5), .div7(div7),
        .cnt3(s_cnt3), .cnt5(s_cnt5), .cnt7(s_cnt7),
        .ok  (s_ok), .done(s_done), .lock(s_lock)
`ifdef FREQ_DIV_MON_STICKY_ERR_EN
        ,.err_clr(err_clr)
        ,.err    (s_err)
`endif
    );

    // Edges of a period-p square wave in one window, clipped at the counter ceiling.
    function automatic int exp_cnt(input int p, input int cw);
        int c;
        c = (p == 0) ? 0 : WIN / p;
        if (c > (1 << cw) - 1) c = (1 << cw) - 1;
        return c;
    endfunction

    function automatic logic [2:0] exp_ok(input int c3, input int c5, input int c7);
        int c[3];
        logic [2:0] r;
        c[0] = c3; c[1] = c5; c[2] = c7;
        for (int i = 0; i < 3; i++) begin
            int ideal = WIN / (3 + 2 * i);
            int d = (c[i] > ideal) ? c[i] - ideal : ideal - c[i];
            r[i] = (d <= TOL);
        end
        return r;
    endfunction

    function automatic logic model_lock(input logic [2:0] o);
        if (o == 3'b111) begin
            if (m_run < LOCK_N) m_run++;
        end else begin
            m_run = 0;
        end
        return (m_run >= LOCK_N);
    endfunction

    task automatic wait_done(input int limit, output int n, output bit got);
        got = 1'b0;
        n   = 0;
        while (!got && n < limit) begin
            @(posedge clk); #1;
            n++;
            if (done === 1'b1) got = 1'b1;
        end
    endtask

    task automatic restart();
        en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; force5 = 1'b0;
        per[0] = 3; per[1] = 5; per[2] = 7;
        stuck[0] = 0; stuck[1] = 0; stuck[2] = 0;
`ifdef FREQ_DIV_MON_STICKY_ERR_EN
        err_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        n_run++;
        if ({cnt3, cnt5, cnt7, ok, done, lock} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", {cnt3, cnt5, cnt7, ok, done, lock});
        end
        n_run++;
        if ({s_cnt3, s_cnt5, s_cnt7, s_ok, s_done, s_lock} !== '0) begin
            n_fail++; $display("FAIL reset_outputs_cw6: got %h want 0", {s_cnt3, s_cnt5, s_cnt7, s_ok});
        end
`ifdef FREQ_DIV_MON_STICKY_ERR_EN
        n_run++;
        if (err !== 3'b000) begin n_fail++; $display("FAIL reset_err: got %b want 000", err); end
`endif
        rst = 1'b0;
        m_run = 0;
    endtask

    task automatic test_first_window();
        int n; bit got; logic el;
        en = 1'b1;
        wait_done(400, n, got);
        n_run++;
        if (!got || n != 215) begin n_fail++; $display("FAIL first_done_latency: got %0d (seen=%0b) want 215", n, got); end
        el = model_lock(3'b111);
        n_run++;
        if ({cnt3, cnt5, cnt7} !== {8'd70, 8'd42, 8'd30}) begin
            n_fail++; $display("FAIL first_counts: got %0d/%0d/%0d want 70/42/30", cnt3, cnt5, cnt7);
        end
        n_run++;
        if (ok !== 3'b111 || lock !== el) begin n_fail++; $display("FAIL first_ok_lock: got %b/%b want 111/%b", ok, lock, el); end
        @(posedge clk); #1;
        n_run++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b want 0", done); end
        wait_done(260, n, got);
        el = model_lock(3'b111);
        n_run++;
        if (!got || n != 209) begin n_fail++; $display("FAIL back_to_back_period: got %0d want 209", n); end
        n_run++;
        if (lock !== el || el !== 1'b1) begin n_fail++; $display("FAIL second_done_lock: got %b want %b", lock, el); end
    endtask

    task automatic test_stuck_div5();
        int n; bit got; logic el;
        repeat (208) @(posedge clk);
        #1; force5 = 1'b1;
        wait_done(300, n, got);
        el = model_lock(3'b111);
        n_run++;
        if (!got || cnt5 !== 8'd42 || ok !== 3'b111 || lock !== el) begin
            n_fail++; $display("FAIL pre_stuck_window: got cnt5=%0d ok=%b lock=%b want 42/111/%b", cnt5, ok, lock, el);
        end
        wait_done(300, n, got);
        el = model_lock(3'b101);
        n_run++;
        if (!got || cnt5 !== 8'd0 || ok !== 3'b101) begin
            n_fail++; $display("FAIL stuck_div5: got cnt5=%0d ok=%b want 0/101", cnt5, ok);
        end
        n_run++;
        if (lock !== el) begin n_fail++; $display("FAIL stuck_lock_drop: got %b want %b", lock, el); end
        force5 = 1'b0;
        wait_done(300, n, got);
        el = model_lock(3'b111);
        n_run++;
        if (!got || ok !== 3'b111 || lock !== el) begin
            n_fail++; $display("FAIL release_window: got ok=%b lock=%b want 111/%b", ok, lock, el);
        end
        wait_done(300, n, got);
        el = model_lock(3'b111);
        n_run++;
        if (!got || cnt5 !== 8'd42 || lock !== el) begin
            n_fail++; $display("FAIL relock: got cnt5=%0d lock=%b want 42/%b", cnt5, lock, el);
        end
    endtask

    task automatic test_div2();
        int n; bit got; logic el; logic [2:0] eo;
        restart();
        per[0] = 2;
        en = 1'b1;
        wait_done(400, n, got);
        eo = exp_ok(exp_cnt(2, CW), exp_cnt(5, CW), exp_cnt(7, CW));
        el = model_lock(eo);
        n_run++;
        if (!got || cnt3 !== 8'(exp_cnt(2, CW)) || ok !== eo || lock !== el) begin
            n_fail++; $display("FAIL div2_cnt3: got %0d ok=%b lock=%b want %0d/%b/%b", cnt3, ok, lock, exp_cnt(2, CW), eo, el);
        end
        n_run++;
        if (s_cnt3 !== 6'(exp_cnt(2, CW6)) || s_ok[0] !== 1'b0) begin
            n_fail++; $display("FAIL div2_saturate_cw6: got %0d ok0=%b want %0d/0", s_cnt3, s_ok[0], exp_cnt(2, CW6));
        end
    endtask

    task automatic test_en_drop();
        int n, seen; bit got; logic el;
        restart();
        per[0] = 3;
        en = 1'b1;
        wait_done(400, n, got);
        el = model_lock(3'b111);
        n_run++;
        if (!got || {cnt3, cnt5, cnt7} !== {8'd70, 8'd42, 8'd30} || lock !== el) begin
            n_fail++; $display("FAIL pre_drop_window: got %0d/%0d/%0d lock=%b want 70/42/30/%b", cnt3, cnt5, cnt7, lock, el);
        end
        repeat (99) @(posedge clk);
        #1; en = 1'b0;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        n_run++;
        if (seen != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
        n_run++;
        if ({cnt3, cnt5, cnt7, ok, lock} !== {8'd70, 8'd42, 8'd30, 3'b111, el}) begin
            n_fail++; $display("FAIL abort_hold: got %0d/%0d/%0d %b %b want 70/42/30 111 %b", cnt3, cnt5, cnt7, ok, lock, el);
        end
        en = 1'b1;
        wait_done(400, n, got);
        el = model_lock(3'b111);
        n_run++;
        if (!got || n != 215 || {cnt3, cnt5, cnt7} !== {8'd70, 8'd42, 8'd30} || lock !== el) begin
            n_fail++; $display("FAIL reenable_window: got n=%0d %0d/%0d/%0d lock=%b want 215 70/42/30 %b", n, cnt3, cnt5, cnt7, lock, el);
        end
    endtask

    task automatic test_random();
        int ptab[8];
        int n, nw, e3, e5, e7, pick;
        bit got; logic el; logic [2:0] eo;
        ptab = '{0, 2, 6, 10, 14, 15, 21, 30};
        for (int it = 0; it < 6; it++) begin
            restart();
            for (int c = 0; c < 3; c++) begin
                pick     = $urandom_range(0, 11);
                per[c]   = (pick < 4) ? 3 + 2 * c : ptab[pick - 4];
                stuck[c] = $urandom_range(0, 1);
            end
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1; en = 1'b1;
            nw = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++) begin
                wait_done(450, n, got);
                e3 = exp_cnt(per[0], CW); e5 = exp_cnt(per[1], CW); e7 = exp_cnt(per[2], CW);
                eo = exp_ok(e3, e5, e7);
                el = model_lock(eo);
                n_run++;
                if (!got || {cnt3, cnt5, cnt7} !== {8'(e3), 8'(e5), 8'(e7)}) begin
                    n_fail++; $display("FAIL rand_counts it%0d: got %0d/%0d/%0d want %0d/%0d/%0d", it, cnt3, cnt5, cnt7, e3, e5, e7);
                end
                n_run++;
                if (ok !== eo || lock !== el) begin
                    n_fail++; $display("FAIL rand_ok_lock it%0d: got %b/%b want %b/%b", it, ok, lock, eo, el);
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        int n; bit got; logic el;
        restart();
        per[0] = 3; per[1] = 5; per[2] = 7;
        en = 1'b1;
        for (int w = 0; w < 2; w++) begin
            wait_done(450, n, got);
            el = model_lock(3'b111);
        end
        n_run++;
        if (!got || lock !== 1'b1 || el !== 1'b1) begin n_fail++; $display("FAIL locked_before_rst: got %b want 1", lock); end
        repeat (50) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        m_run = 0;
        n_run++;
        if ({cnt3, cnt5, cnt7, ok, done, lock} !== '0) begin
            n_fail++; $display("FAIL rst_mid_window: got %h want 0", {cnt3, cnt5, cnt7, ok, done, lock});
        end
        rst = 1'b0;
        wait_done(400, n, got);
        el = model_lock(3'b111);
        n_run++;
        if (!got || n != 215 || cnt7 !== 8'd30 || lock !== el) begin
            n_fail++; $display("FAIL after_rst_window: got n=%0d cnt7=%0d lock=%b want 215/30/%b", n, cnt7, lock, el);
        end
    endtask

`ifdef FREQ_DIV_MON_STICKY_ERR_EN
    task automatic test_sticky_err();
        int n; bit got; logic el;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        n_run++;
        if (err !== 3'b000) begin n_fail++; $display("FAIL err_initial_clear: got %b want 000", err); end
        restart();
        per[2] = 3;
        en = 1'b1;
        wait_done(400, n, got);
        el = model_lock(3'b011);
        n_run++;
        if (!got || ok !== 3'b011 || err !== 3'b100 || lock !== el) begin
            n_fail++; $display("FAIL err_set: got ok=%b err=%b want 011/100", ok, err);
        end
        restart();
        per[2] = 7;
        en = 1'b1;
        for (int w = 0; w < 2; w++) begin
            wait_done(400, n, got);
            el = model_lock(3'b111);
            n_run++;
            if (!got || ok !== 3'b111 || err !== 3'b100) begin
                n_fail++; $display("FAIL err_persist w%0d: got ok=%b err=%b want 111/100", w, ok, err);
            end
        end
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        n_run++;
        if (err !== 3'b000) begin n_fail++; $display("FAIL err_clr: got %b want 000", err); end
        restart();
        per[2] = 3;
        en = 1'b1;
        repeat (214) @(posedge clk);
        #1; err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        el = model_lock(3'b011);
        n_run++;
        if (done !== 1'b1 || err !== 3'b100 || ok !== 3'b011) begin
            n_fail++; $display("FAIL err_set_beats_clr: got done=%b err=%b ok=%b want 1/100/011", done, err, ok);
        end
    endtask
`endif

    initial begin
        n_run  = 0;
        n_fail = 0;
        m_run  = 0;
        test_reset();
        test_first_window();
        test_stuck_div5();
        test_div2();
        test_en_drop();
        test_random();
        test_rst_mid();
`ifdef FREQ_DIV_MON_STICKY_ERR_EN
        test_sticky_err();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
